parallel_intt_32bit: RTL and testbench
======================================

# parallel_intt_32bit

Inverse number-theoretic transform for Dilithium (q = 8380417, n = 256). It is the inverse stage of `parallel_ntt_32bit` and shares its `clock`/`reset`/`start`/`done` handshake and flat 256×32-bit bus format. It takes NTT-domain coefficients and returns normal-domain coefficients, so that `intt(ntt(a)) = a mod q`. Internally it holds a 256-entry coefficient bank and runs 8 Gentleman–Sande butterfly layers, `NUM_BF` butterflies per cycle, followed by a multiply-by-n⁻¹ pass.

## Interface
- `NUM_BF`, default 4: butterflies per cycle. Legal values are 1, 2, 4, 8.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: level request. Sampled only in IDLE.
- `inp`  in  signed [0:8191]: coefficient i is `inp[i*32 +: 32]`, signed 32-bit, any value.
- `done`  out  1: level. High only in DONE.
- `out`  out  [0:8191]: coefficient i is `out[i*32 +: 32]`, in [0, q), zero-extended. Valid only while `done` is high.

## Operation
- States are IDLE → LAYER → SCALE → DONE.
  - IDLE, `start` = 1: on that edge, each `inp` coefficient is reduced to [0, q) with signed modulo and written into the bank. Clear layer and butterfly counters, go to LAYER.
  - LAYER: layer l = 0..7, len = 2^l. Each cycle processes butterfly indices b = c·NUM_BF … c·NUM_BF + NUM_BF − 1 (b in 0..127):
    - g = b >> l, j = g·2·len + (b & (len − 1)), partner = j + len, k = (256 >> l) − 1 − g.
    - t = a[j], u = a[partner].
    - a[j] ← (t + u) mod q.
    - a[partner] ← ((u − t) mod q) · zetas[k] mod q.
    - Butterflies within one cycle never share an index, so all writes happen on the same edge. Layer l+1 reads the results written by layer l.
    - After the last cycle of layer 7, go to SCALE.
  - SCALE: each cycle, NUM_BF consecutive coefficients a[i] ← a[i] · N_INV mod q, where N_INV = 8347681 (256⁻¹ mod q). After coefficient 255, go to DONE.
  - DONE: `done` = 1. Go to IDLE on the first edge where `start` = 0. While `start` stays high, remain in DONE; there is no re-trigger.
- Twiddles: zetas[k] = 1753^brv8(k) mod q, plain residues with no Montgomery form. zetas[0] is unused.
- `out` is driven directly from the bank, so it shows intermediate values while not in DONE.
- All modular results are canonical, in [0, q). Products are 46-bit, reduced by Barrett. No lazy reduction is allowed.

## Timing
- Reset values: state IDLE, `done` = 0, bank all zero, hence `out` = 0, counters 0.
- Latency: the first edge with `done` = 1 is (1 + 1280/NUM_BF) edges after the capturing edge. For NUM_BF = 4 that is 1 + 256 + 64 = 321.
- `done` falls on the edge after `start` is sampled low in DONE. A new `start` is then accepted in IDLE one cycle later at the earliest.
- `start` asserted outside IDLE is ignored.
- `inp` is sampled only on the capturing edge. Later changes have no effect.
- `reset` asserted at any time, including mid-LAYER or mid-SCALE, aborts immediately: IDLE, `done` = 0, bank cleared. There is no partial result.

## Structure
- Package `dilithium_pkg` holds:
  - Q, N = 256, ZETA = 1753, N_INV, coefficient width 23.
  - The 256-entry zetas ROM, as a constant array or function, shared with `parallel_ntt_32bit`.
  - Barrett constants.
- Sub-module `gs_butterfly`: combinational (t, u, zeta) → (t + u, (u − t)·zeta) mod q, containing one modular multiplier.
  - Instantiate it NUM_BF times.
  - SCALE reuses the same multipliers, with the t/u path bypassed.
- The top level contains the FSM, layer/butterfly counters, address generation, and the bank.

## Test plan
- Round trip: drive `inp` with the `parallel_ntt_32bit` output for a = [1, 2, …, 256]. Required: `out[i]` = i + 1 for all i, and `done` rises exactly 321 edges after capture (NUM_BF = 4).
- All-ones input (every coefficient = 1). Required: `out[0]` = 1 and `out[1..255]` = 0. Repeat with every coefficient = −1: `out[0]` = 8380416, rest 0. Repeat with every coefficient = q + 1: `out[0]` = 1, rest 0.
- All-zero input. Required: all `out` = 0 and `done` timing as above.
- Handshake: hold `start` high after `done`. Required: `done` stays 1 and `out` is stable for more than 100 cycles. Drop `start`: `done` = 0 on the next edge. Re-assert `start`: a second run matches the reference result.
- Reset at cycle 100 of a run. Required: `done` = 0 and `out` = 0 immediately. A following `start` gives the correct round-trip result with normal latency.
- Parameter sweep NUM_BF ∈ {1, 2, 8} on the round-trip vector. Required: identical `out`, with latencies 1281, 641 and 161.

Source files
------------

// File: rtl/dilithium_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dilithium_pkg
// Description : Shared Dilithium arithmetic constants and helpers: modulus,
//               n^-1, Barrett constants, twiddle ROM generator, signed input
//               reduction and canonical modular multiply.
// Revision    : 1.0 - initial release
// ============================================================================
package dilithium_pkg;

    localparam int          COEF_W    = 23;
    localparam int          N         = 256;
    localparam int          ZETA      = 1753;
    localparam logic [23:0] Q         = 24'd8380417;
    localparam logic signed [31:0] Q_SIGNED = 32'sd8380417;

    typedef logic [COEF_W-1:0] coef_t;

    localparam coef_t       N_INV     = 23'd8347681;

    // Barrett: products are below q^2 < 2^46, so m = floor(2^46 / q)
    // leaves at most one correction subtraction.
    localparam int          BARRETT_K = 46;
    localparam logic [23:0] BARRETT_M = 24'((64'd1 << BARRETT_K) / 64'(Q));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LAYER = 2'd1,
        S_SCALE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // zetas[k] = ZETA^brv8(k) mod q, plain residue. Evaluated at elaboration
    // to build a constant ROM.
    function automatic coef_t zeta_of(input logic [7:0] k);
        logic [63:0] acc;
        logic [63:0] base;
        logic [7:0]  e;
        for (int i = 0; i < 8; i++) e[i] = k[7-i];
        acc  = 64'd1;
        base = 64'(ZETA);
        for (int i = 0; i < 8; i++) begin
            if (e[i]) acc = (acc * base) % 64'(Q);
            base = (base * base) % 64'(Q);
        end
        return coef_t'(acc);
    endfunction

    // Signed modulo into [0, q); SV % keeps the dividend's sign.
    function automatic coef_t reduce_signed(input logic signed [31:0] v);
        logic signed [31:0] r;
        r = v % Q_SIGNED;
        if (r < 0) r = r + Q_SIGNED;
        return coef_t'(r);
    endfunction

    // Canonical a*b mod q for canonical a, b.
    function automatic coef_t mod_mul(input coef_t a, input coef_t b);
        logic [45:0] x;
        logic [23:0] qh;
        logic [45:0] r;
        x  = {23'd0, a} * {23'd0, b};
        qh = 24'(({24'd0, x} * {46'd0, BARRETT_M}) >> BARRETT_K);
        r  = x - ({22'd0, qh} * {22'd0, Q});
        if (r >= {22'd0, Q}) r = r - {22'd0, Q};
        return coef_t'(r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/parallel_intt_32bit_if.sv
`default_nettype none
// ============================================================================
// Module      : parallel_intt_32bit_if
// Description : Handshake and coefficient bus of the INTT.
//               start : level request, sampled in IDLE
//               inp   : 256 x signed 32-bit coefficients, i at [i*32 +: 32]
//               done  : high while the result is valid
//               out   : 256 x 32-bit canonical coefficients
// Revision    : 1.0 - initial release
// ============================================================================
interface parallel_intt_32bit_if;
    logic               start;
    logic signed [0:8191] inp;
    logic               done;
    logic [0:8191]      out;

    modport master (output start, output inp, input done, input out);
    modport slave  (input start, input inp, output done, output out);
endinterface
`default_nettype wire

// File: rtl/gs_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : gs_butterfly
// Description : Combinational Gentleman-Sande butterfly mod q.
//               o_sum  = (t + u) mod q
//               o_prod = ((u - t) mod q) * zeta mod q, or t * zeta mod q when
//                        i_scale is set (t/u difference bypassed).
// Revision    : 1.0 - initial release
// ============================================================================
module gs_butterfly
    import dilithium_pkg::*;
(
    input  wire   i_scale,
    input  coef_t i_t,
    input  coef_t i_u,
    input  coef_t i_zeta,
    output coef_t o_sum,
    output coef_t o_prod
);

    logic [23:0] w_sum_raw;
    coef_t       w_diff;
    coef_t       w_mul_a;

    always_comb begin
        w_sum_raw = {1'b0, i_t} + {1'b0, i_u};
        o_sum     = (w_sum_raw >= Q) ? coef_t'(w_sum_raw - Q) : coef_t'(w_sum_raw);
        w_diff    = (i_u >= i_t) ? (i_u - i_t)
                                 : coef_t'({1'b0, i_u} + Q - {1'b0, i_t});
        w_mul_a   = i_scale ? i_t : w_diff;
        o_prod    = mod_mul(w_mul_a, i_zeta);
    end

endmodule
`default_nettype wire

// File: rtl/parallel_intt_32bit.sv
`default_nettype none
// ============================================================================
// Module      : parallel_intt_32bit
// Description : Dilithium inverse NTT (q = 8380417, n = 256). Captures and
//               reduces 256 coefficients, runs 8 GS layers with NUM_BF
//               butterflies per cycle, then scales by n^-1.
//               clock, reset (async, active-high), bus (slave modport).
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_intt_32bit
    import dilithium_pkg::*;
#(
    parameter int NUM_BF = 4
) (
    input  wire                  clock,
    input  wire                  reset,
    parallel_intt_32bit_if.slave bus
);

    localparam logic [7:0] C_LAYER_LAST = 8'(128 / NUM_BF - 1);
    localparam logic [7:0] C_SCALE_LAST = 8'(256 / NUM_BF - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_done;
    logic [2:0]  r_layer;
    logic [7:0]  r_cnt;
    coef_t       r_bank [N];
    coef_t       w_zetas [N];

    logic [7:0]  w_len;
    logic [7:0]  w_idx [NUM_BF];
    logic [7:0]  w_g   [NUM_BF];
    logic [7:0]  w_j   [NUM_BF];
    logic [7:0]  w_p   [NUM_BF];
    logic [7:0]  w_k   [NUM_BF];
    coef_t       w_t   [NUM_BF];
    coef_t       w_u   [NUM_BF];
    coef_t       w_z   [NUM_BF];
    coef_t       w_sum [NUM_BF];
    coef_t       w_prod[NUM_BF];
    logic        w_scale;
    logic [0:8191] w_out;

    // Twiddle ROM, folded to constants at elaboration.
    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam coef_t C_ZETA = zeta_of(8'(k));
        assign w_zetas[k] = C_ZETA;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_LAYER;
            S_LAYER: if (r_cnt == C_LAYER_LAST && r_layer == 3'd7) w_state_nxt = S_SCALE;
            S_SCALE: if (r_cnt == C_SCALE_LAST) w_state_nxt = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                if (!bus.start) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- address generation ----------------
    // Layer: b = cnt*NUM_BF + lane, g = b >> l, j = g*2*len + (b & (len-1)),
    // partner = j + len, k = (256 >> l) - 1 - g. Scale: lane index is the
    // coefficient address and the multiplier sees t * N_INV.
    assign w_scale = (r_state == S_SCALE);

    always_comb begin
        w_len = 8'd1 << r_layer;
        for (int ln = 0; ln < NUM_BF; ln++) begin
            w_idx[ln] = 8'(int'(r_cnt) * NUM_BF + ln);
            w_g[ln]   = w_idx[ln] >> r_layer;
            w_j[ln]   = ((w_g[ln] << r_layer) << 1) | (w_idx[ln] & (w_len - 8'd1));
            w_p[ln]   = w_j[ln] + w_len;
            w_k[ln]   = (8'd255 >> r_layer) - w_g[ln];
            if (w_scale) begin
                w_t[ln] = r_bank[w_idx[ln]];
                w_u[ln] = '0;
                w_z[ln] = N_INV;
            end else begin
                w_t[ln] = r_bank[w_j[ln]];
                w_u[ln] = r_bank[w_p[ln]];
                w_z[ln] = w_zetas[w_k[ln]];
            end
        end
    end

    for (genvar ln = 0; ln < NUM_BF; ln++) begin : g_lane
        gs_butterfly u_bf (
            .i_scale (w_scale),
            .i_t     (w_t[ln]),
            .i_u     (w_u[ln]),
            .i_zeta  (w_z[ln]),
            .o_sum   (w_sum[ln]),
            .o_prod  (w_prod[ln])
        );
    end

    // ---------------- bank and counters ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_layer <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < N; i++) r_bank[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_layer <= '0;
                        r_cnt   <= '0;
                        for (int i = 0; i < N; i++)
                            r_bank[i] <= reduce_signed($signed(bus.inp[i*32 +: 32]));
                    end
                end
                S_LAYER: begin
                    for (int ln = 0; ln < NUM_BF; ln++) begin
                        r_bank[w_j[ln]] <= w_sum[ln];
                        r_bank[w_p[ln]] <= w_prod[ln];
                    end
                    if (r_cnt == C_LAYER_LAST) begin
                        r_cnt   <= '0;
                        r_layer <= r_layer + 3'd1;  // wraps to 0 entering SCALE
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_SCALE: begin
                    for (int ln = 0; ln < NUM_BF; ln++)
                        r_bank[w_idx[ln]] <= w_prod[ln];
                    r_cnt <= (r_cnt == C_SCALE_LAST) ? 8'd0 : r_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_out = '0;
        for (int i = 0; i < N; i++) w_out[i*32 +: 32] = {9'd0, r_bank[i]};
    end

    assign bus.out  = w_out;
    assign bus.done = w_done;

endmodule
`default_nettype wire

// File: tb/tb_parallel_intt_32bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_parallel_intt_32bit
// Description : Self-checking bench for parallel_intt_32bit. Expected output
//               vectors are queued when a run starts and popped when done is
//               seen. Round-trip stimulus comes from a forward NTT model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_parallel_intt_32bit;

    localparam longint C_Q = 8380417;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    longint sb_q[$];

    logic signed [0:8191] vec_rt;
    logic signed [0:8191] vec_off;

    parallel_intt_32bit_if dut_if();
    parallel_intt_32bit #(.NUM_BF(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (dut_if)
    );

    // Parameter sweep instances: NUM_BF = 1, 2, 8.
    logic                 sw_start;
    logic signed [0:8191] sw_inp;
    logic [2:0]           sw_done;
    logic [0:8191]        sw_out [3];

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int C_BF = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        parallel_intt_32bit_if sw_if();
        assign sw_if.start = sw_start;
        assign sw_if.inp   = sw_inp;
        assign sw_done[g]  = sw_if.done;
        assign sw_out[g]   = sw_if.out;
        parallel_intt_32bit #(.NUM_BF(C_BF)) u_sw (
            .clock (clock),
            .reset (reset),
            .bus   (sw_if)
        );
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int count_nz(input logic [0:8191] v);
        int c = 0;
        for (int i = 0; i < 256; i++) if (v[i*32 +: 32] != 32'd0) c++;
        return c;
    endfunction

    // Forward NTT of a = [1..256] (plain-residue Cooley-Tukey).
    task automatic build_vectors();
        longint pw[256];
        longint zt[256];
        longint a[256];
        longint z, t;
        int k, br, m;
        pw[0] = 1;
        for (int e = 1; e < 256; e++) pw[e] = (pw[e-1] * 1753) % C_Q;
        for (int i = 0; i < 256; i++) begin
            br = 0;
            for (int b = 0; b < 8; b++) if (((i >> b) & 1) == 1) br = br | (1 << (7 - b));
            zt[i] = pw[br];
        end
        for (int i = 0; i < 256; i++) a[i] = i + 1;
        k = 0;
        for (int len = 128; len > 0; len = len / 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                k++;
                z = zt[k];
                for (int j = st; j < st + len; j++) begin
                    t        = (z * a[j+len]) % C_Q;
                    a[j+len] = (a[j] - t + C_Q) % C_Q;
                    a[j]     = (a[j] + t) % C_Q;
                end
            end
        end
        for (int i = 0; i < 256; i++) begin
            vec_rt[i*32 +: 32] = 32'(a[i]);
            m = int'($urandom_range(400)) - 200;     // same residues, shifted by multiples of q
            vec_off[i*32 +: 32] = 32'(a[i] + C_Q * longint'(m));
        end
    endtask

    task automatic push_rt();
        for (int i = 0; i < 256; i++) sb_q.push_back(longint'(i + 1));
    endtask

    task automatic push_delta(input longint v0);
        sb_q.push_back(v0);
        for (int i = 1; i < 256; i++) sb_q.push_back(0);
    endtask

    task automatic compare_out(input string tag, input logic [0:8191] o);
        longint e;
        for (int i = 0; i < 256; i++) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_underflow"}, 0, 1);
                return;
            end
            e = sb_q.pop_front();
            chk($sformatf("%s_out[%0d]", tag, i), longint'(o[i*32 +: 32]), e);
        end
    endtask

    // Latency = index of the first rising edge (counting from 1 after the
    // capturing edge) at which done is already high.
    task automatic run_main(input string tag, input logic [0:8191] vec, input bit hold);
        int n;
        @(negedge clock);
        dut_if.inp   = vec;
        dut_if.start = 1'b1;
        @(posedge clock);
        #1;
        dut_if.inp = {256{$urandom()}};
        if (!hold) dut_if.start = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(negedge clock);
            if (dut_if.done) break;
            @(posedge clock);
            n++;
        end
        chk({tag, "_latency"}, n + 1, 321);
        compare_out(tag, dut_if.out);
        if (!hold) begin
            @(posedge clock);
            @(negedge clock);
            chk({tag, "_done_fall"}, dut_if.done, 0);
        end
    endtask

    initial begin
        logic [0:8191] snap;
        int nchg, nlow, n;
        int lat[3];
        int exp_lat[3];
        exp_lat = '{1281, 641, 161};

        dut_if.start = 1'b0;
        dut_if.inp   = '0;
        sw_start     = 1'b0;
        sw_inp       = '0;
        build_vectors();

        repeat (3) @(negedge clock);
        chk("reset_done", dut_if.done, 0);
        chk("reset_out_nonzero", count_nz(dut_if.out), 0);
        reset = 1'b0;

        push_rt();         run_main("rt",     vec_rt,                      1'b0);
        push_delta(1);     run_main("ones",   {256{32'd1}},                1'b0);
        push_delta(C_Q-1); run_main("minus1", {256{32'hFFFF_FFFF}},        1'b0);
        push_delta(1);     run_main("qp1",    {256{32'd8380418}},          1'b0);
        push_delta(0);     run_main("zero",   '0,                          1'b0);
        push_rt();         run_main("rt_off", vec_off,                     1'b0);

        // start held high across DONE
        push_rt();         run_main("hold",   vec_rt,                      1'b1);
        snap = dut_if.out;
        nchg = 0;
        nlow = 0;
        repeat (120) begin
            @(negedge clock);
            if (dut_if.out !== snap) nchg++;
            if (!dut_if.done) nlow++;
        end
        chk("hold_out_changes", nchg, 0);
        chk("hold_done_low", nlow, 0);
        dut_if.start = 1'b0;
        @(posedge clock);
        #1;
        chk("drop_done", dut_if.done, 0);
        push_rt();         run_main("rerun",  vec_off,                     1'b0);

        // reset 100 cycles into a run
        @(negedge clock);
        dut_if.inp   = vec_rt;
        dut_if.start = 1'b1;
        @(posedge clock);
        #1 dut_if.start = 1'b0;
        repeat (100) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_done", dut_if.done, 0);
        chk("abort_out_nonzero", count_nz(dut_if.out), 0);
        @(negedge clock);
        reset = 1'b0;
        push_rt();         run_main("after_reset", vec_rt,                 1'b0);

        // NUM_BF sweep
        for (int g = 0; g < 3; g++) push_rt();
        @(negedge clock);
        sw_inp   = vec_rt;
        sw_start = 1'b1;
        @(posedge clock);
        #1;
        sw_start = 1'b0;
        sw_inp   = {256{$urandom()}};
        lat = '{0, 0, 0};
        n = 0;
        while (n < 1500 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
            @(negedge clock);
            for (int g = 0; g < 3; g++) if (sw_done[g] && lat[g] == 0) lat[g] = n + 1;
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("sweep%0d_latency", g), lat[g], exp_lat[g]);
            compare_out($sformatf("sweep%0d", g), sw_out[g]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
